// File: rtl/alu_sel_pkg.sv
// Shared opcode constants and map helpers for the ALU result selector.
// The default map packs one {legal, idx} entry per opcode, entry k at k*(IDX_W+1).
package alu_sel_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_OR   = 4'd5;
    localparam logic [ALU_OP_W-1:0] OP_XOR  = 4'd6;
    localparam logic [ALU_OP_W-1:0] OP_SHL  = 4'd7;
    localparam logic [ALU_OP_W-1:0] OP_SHR  = 4'd8;
    localparam logic [ALU_OP_W-1:0] OP_CMP  = 4'd9;
    localparam logic [ALU_OP_W-1:0] OP_PASS = 4'd11;

    localparam int DEF_N_OPS   = 9;
    localparam int DEF_IDX_W   = 4;

    function automatic int map_entry_w(input int idx_w);
        return idx_w + 1;
    endfunction

    localparam int DEF_ENTRY_W = map_entry_w(DEF_IDX_W);
    localparam int DEF_MAP_W   = (2**ALU_OP_W) * DEF_ENTRY_W;

    // Listed in source order: the opcode at position i selects source i.
    localparam logic [DEF_N_OPS*ALU_OP_W-1:0] DEF_SLOTS =
        {OP_PASS, OP_CMP, OP_SHR, OP_SHL, OP_XOR, OP_OR, OP_AND, OP_SUB, OP_ADD};

    function automatic logic [DEF_MAP_W-1:0] default_op_map();
        logic [DEF_MAP_W-1:0] m;
        m = '0;
        for (int i = 0; i < DEF_N_OPS; i++)
            m[int'(DEF_SLOTS[i*ALU_OP_W +: ALU_OP_W])*DEF_ENTRY_W +: DEF_ENTRY_W] =
                {1'b1, DEF_IDX_W'(i)};
        return m;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Opcode to {legal, source index} lookup. A mapped entry pointing past the
// last source is reported as illegal so the datapath never indexes off the end.
module alu_op_decode
    import alu_sel_pkg::*;
#(
    parameter int N_SRC = 9,
    parameter int OP_W  = 4,
    parameter int IDX_W = 4,
    parameter logic [(2**OP_W)*(IDX_W+1)-1:0] OP_MAP = default_op_map()
) (
    input  logic [OP_W-1:0]  op_i,
    output logic             legal_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam int EW = map_entry_w(IDX_W);

    logic [EW-1:0] entry;
    logic          in_range;

    always_comb begin
        entry    = OP_MAP[int'(op_i)*EW +: EW];
        in_range = int'({1'b0, entry[IDX_W-1:0]}) < N_SRC;
        legal_o  = entry[IDX_W] && in_range;
        idx_o    = legal_o ? entry[IDX_W-1:0] : '0;
    end

endmodule

// File: rtl/alu_result_sel_pipe.sv
// Registered ALU result selector: opcode-mapped source select behind one
// valid/ready stage, with a saturating illegal-opcode counter for debug.
module alu_result_sel_pipe
    import alu_sel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_SRC = 9,
    parameter int OP_W  = 4,
    parameter int IDX_W = 4,
    parameter logic [(2**OP_W)*(IDX_W+1)-1:0] OP_MAP = default_op_map(),
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [N_SRC*WIDTH-1:0] in_src,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [OP_W-1:0]        out_op,
    output logic                   out_illegal,
    output logic [CNT_W-1:0]       illegal_cnt,
    input  logic                   cnt_clr
);

    logic             legal;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] sel_data;
    logic             accept;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    alu_op_decode #(
        .N_SRC (N_SRC),
        .OP_W  (OP_W),
        .IDX_W (IDX_W),
        .OP_MAP(OP_MAP)
    ) u_dec (
        .op_i   (in_op),
        .legal_o(legal),
        .idx_o  (idx)
    );

    // Compare-and-or mux keeps every slice in range; illegal ops yield zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++)
            if (legal && idx == IDX_W'(i))
                sel_data = in_src[i*WIDTH +: WIDTH];
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        op_d    = op_q;
        ill_d   = ill_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            op_d    = in_op;
            ill_d   = !legal;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        // Clear takes effect first so a same-cycle illegal accept counts as 1.
        cnt_d = cnt_clr ? '0 : cnt_q;
        if (accept && !legal && cnt_d != '1)
            cnt_d = cnt_d + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_op      = op_q;
    assign out_illegal = ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Scoreboard bench for alu_result_sel_pipe: directed stimulus pushes expected
// results, a negedge monitor pops and checks each output transfer.
module tb_alu_result_sel_pipe;
    import alu_sel_pkg::*;

    localparam int WIDTH = 8;
    localparam int N_SRC = 9;
    localparam int OP_W  = 4;
    localparam int IDX_W = 4;
    localparam int CNT_W = 2;

    function automatic logic [DEF_MAP_W-1:0] tb_map();
        logic [DEF_MAP_W-1:0] m;
        m = default_op_map();
        m[3*5 +: 5] = {1'b1, 4'd12};
        return m;
    endfunction
    localparam logic [DEF_MAP_W-1:0] TB_MAP = tb_map();

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [OP_W-1:0]        in_op = '0;
    logic [N_SRC*WIDTH-1:0] in_src = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [WIDTH-1:0]       out_data;
    logic [OP_W-1:0]        out_op;
    logic                   out_illegal;
    logic [CNT_W-1:0]       illegal_cnt;
    logic                   cnt_clr = 1'b0;

    alu_result_sel_pipe #(
        .WIDTH(WIDTH), .N_SRC(N_SRC), .OP_W(OP_W), .IDX_W(IDX_W),
        .OP_MAP(TB_MAP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_src(in_src), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_op(out_op),
        .out_illegal(out_illegal), .illegal_cnt(illegal_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [OP_W-1:0]  op;
        logic             ill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next posedge when valid && ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_out: got data %0h op %0h with empty scoreboard",
                             out_data, out_op);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_op", 32'(out_op), 32'(e.op));
                    chk("out_illegal", 32'(out_illegal), 32'(e.ill));
                end
            end
        end
    end

    // Leaves in_valid high so consecutive calls issue back-to-back.
    task automatic send(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] d,
                        input logic ill, input bit push);
        bit ok;
        int n;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 20);
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: op %0h never accepted", op);
        end else if (push) begin
            e.data = d; e.op = op; e.ill = ill;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [OP_W-1:0] legal_ops [9] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11};
    logic [OP_W-1:0] bad_ops   [5] = '{4'd4, 4'd10, 4'd13, 4'd14, 4'd15};

    initial begin
        for (int i = 0; i < N_SRC; i++) in_src[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_op", 32'(out_op), 0);
        chk("rst_out_illegal", 32'(out_illegal), 0);
        chk("rst_cnt", 32'(illegal_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // All legal slots back-to-back, source i = 8'h10+i.
        for (int i = 0; i < 9; i++) send(legal_ops[i], 8'h10 + 8'(i), 1'b0, 1'b1);
        idle(3);
        chk("cnt_after_legal", 32'(illegal_cnt), 0);

        // Unmapped opcode and the in-map-but-out-of-range entry 3.
        send(4'd3, 8'h00, 1'b1, 1'b1);
        send(4'd12, 8'h00, 1'b1, 1'b1);
        idle(3);
        chk("cnt_two_illegal", 32'(illegal_cnt), 2);

        // Backpressure: op 1 held while op 2 waits.
        in_src[1*WIDTH +: WIDTH] = 8'hA5;
        in_src[2*WIDTH +: WIDTH] = 8'h5A;
        out_ready = 1'b0;
        send(4'd1, 8'hA5, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_op    = 4'd2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 0);
            chk("stall_out_data", 32'(out_data), 32'h A5);
            chk("stall_out_op", 32'(out_op), 1);
            chk("stall_out_valid", 32'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'd2, 8'h5A, 1'b0, 1'b1);
        idle(1);
        chk("after_stall_data", 32'(out_data), 32'h5A);
        idle(2);
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_keeps_data", 32'(out_data), 32'h5A);

        // Saturation at 2**CNT_W-1 = 3, then clear and count in one cycle.
        for (int i = 0; i < 5; i++) send(bad_ops[i], 8'h00, 1'b1, 1'b1);
        idle(2);
        chk("cnt_saturated", 32'(illegal_cnt), 3);
        cnt_clr = 1'b1;
        send(4'd15, 8'h00, 1'b1, 1'b1);
        cnt_clr = 1'b0;
        idle(2);
        chk("cnt_clr_plus_illegal", 32'(illegal_cnt), 1);
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        chk("cnt_clr_alone", 32'(illegal_cnt), 0);

        // Stalled illegal op: counted once on accept, then discarded by reset.
        out_ready = 1'b0;
        send(4'd4, 8'h00, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_op    = 4'd10;
        idle(0);
        in_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("stalled_not_counted", 32'(illegal_cnt), 1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_data", 32'(out_data), 0);
        chk("async_rst_cnt", 32'(illegal_cnt), 0);
        chk("async_rst_illegal", 32'(out_illegal), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        send(4'd11, 8'h18, 1'b0, 1'b1);
        idle(3);

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_result_sel_pipe.md
Name: alu_result_sel_pipe

Overview:
Parametrised, registered result selector for the ALU output stage. It picks one of N_SRC functional-unit results using a programmable opcode-to-source map. It replaces the combinational 9-way select: illegal opcodes produce a defined zero result with an error flag instead of high-Z, and the output sits behind a single valid/ready register stage. It also counts illegal opcodes for debug. It sits between the ALU functional units and the writeback/display logic.

Parameters:
WIDTH, 8, bit width of each source result and of out_data
N_SRC, 9, number of source results (2..16)
OP_W, 4, opcode width; map has 2**OP_W entries
IDX_W, 4, source index width, >= clog2(N_SRC)
OP_MAP, default map (see Behaviour), packed 2**OP_W entries of {legal, idx[IDX_W-1:0]}; entry k at bits [k*(IDX_W+1) +: IDX_W+1]
CNT_W, 8, illegal-opcode counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operand/opcode bundle valid
in_ready  out  1  stage can accept
in_op  in  OP_W  opcode
in_src  in  N_SRC*WIDTH  packed source results; source i at [i*WIDTH +: WIDTH]
out_valid  out  1  registered result valid
out_ready  in  1  downstream accepts
out_data  out  WIDTH  selected result
out_op  out  OP_W  opcode that produced out_data
out_illegal  out  1  out_data came from an unmapped opcode
illegal_cnt  out  CNT_W  saturating count of accepted illegal opcodes
cnt_clr  in  1  synchronous clear of illegal_cnt

Behaviour:
- One clock, rst_n asynchronous active-low; all state clears immediately on assertion. Release is synchronous to clk.
- Reset values: out_valid=0, out_data=0, out_op=0, out_illegal=0, illegal_cnt=0. in_ready=1 after reset.
- Default OP_MAP (legal→idx): 0→0, 1→1, 2→2, 5→3, 6→4, 7→5, 8→6, 9→7, 11→8. Opcodes 3, 4, 10, 12–15 are illegal.
- Entry with legal=1 but idx>=N_SRC is treated as illegal.
- in_ready = !out_valid || out_ready. This is a combinational pass-through and gives full throughput with no bubbles.
- Accept = in_valid && in_ready. On accept, the next edge loads:
  - out_data = in_src[idx] if legal, else 0
  - out_op = in_op
  - out_illegal = !legal
  - out_valid = 1
- Latency: 1 cycle from accept to out_valid.
- Output held stable (data, op, illegal flag) while out_valid && !out_ready. in_src/in_op are ignored while in_ready=0.
- Drain: out_valid && out_ready && !in_valid → out_valid=0 next edge; out_data keeps its last value.
- Simultaneous drain and accept: the new result is loaded and out_valid stays 1.
- illegal_cnt: +1 on each accepted illegal opcode and saturates at 2**CNT_W-1. Stalled (non-accepted) illegal opcodes are not counted.
- cnt_clr alone → illegal_cnt=0.
- cnt_clr in the same cycle as an illegal accept → illegal_cnt=1 (the clear applies first, then the event is counted).
- Reset mid-transfer: pending result discarded, out_valid=0 immediately; no partial count.
- No X/Z ever driven on outputs once out of reset.

Decomposition:
- Package alu_sel_pkg:
  - opcode constants OP_ADD… matching the default map slots
  - ALU_OP_W=4
  - function building the default OP_MAP
  - MAP_ENTRY_W helper
- One combinational sub-module, alu_op_decode: in_op → {legal, idx} from OP_MAP, including the idx>=N_SRC check.
- The register stage, handshake and counter live in the top.

Test Plan:
- Reset, then accept in_op=0..2,5..9,11 back-to-back with in_src[i]=8'h10+i, out_ready=1 → out_data 8'h10..8'h18 in order, one per cycle, out_illegal=0, illegal_cnt=0.
- in_op=4'd3 then 4'd12, out_ready=1 → out_data=8'h00 with out_illegal=1 both times, out_op echoed, illegal_cnt=2.
- Accept op=1 (src1=8'hA5), hold out_ready=0 for 5 cycles while in_valid=1 with op=2 → in_ready=0, out_data stays 8'hA5, op=2 not taken; raise out_ready → next cycle out_data=src2.
- CNT_W=2: send 5 illegal ops → illegal_cnt saturates at 3. Then cnt_clr together with one more illegal accept → illegal_cnt=1.
- Override OP_MAP entry 3 to {1,4'd12} with N_SRC=9 → op 3 yields out_illegal=1, out_data=0.
- Assert rst_n=0 mid-cycle while out_valid=1 and stalled → out_valid, out_data, illegal_cnt drop to 0 before the next clk edge; after release in_ready=1.
